// File: rtl/alarm_ctrl.sv
// ============================================================================
//  Module   : alarm_ctrl
//  Purpose  : Owns the alarm time and the ringing state. Converts the alarm
//             comparator's level match (buzz) into a latched ring output, with
//             snooze, stop, arm toggle and an automatic ring timeout.
//  Ports    : Clk       - single rising-edge clock
//             Reset     - asynchronous active-high reset
//             buzz      - comparator match level (time == alarm & alarmOn)
//             min_tick  - one-cycle pulse per time-of-day minute
//             setAlarm  - level; enables alarm-time editing while idle
//             advMin    - pulse; advance alarm minute (mod 60, no carry)
//             advHr     - pulse; advance alarm hour (mod 24)
//             armToggle - pulse; invert alarmOn
//             snooze    - pulse; silence and push the alarm SNOOZE_MIN later
//             stop      - pulse; silence and restore the user alarm time
//             amin/ahrs - active compare time fed to the comparator
//             alarmOn   - alarm armed
//             ring      - alarm sounding
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_ctrl #(
  parameter int SNOOZE_MIN = 9,   // 1..59
  parameter int RING_MIN   = 2    // 1..15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       buzz,
  input  logic       min_tick,
  input  logic       setAlarm,
  input  logic       advMin,
  input  logic       advHr,
  input  logic       armToggle,
  input  logic       snooze,
  input  logic       stop,
  output logic [6:0] amin,
  output logic [6:0] ahrs,
  output logic       alarmOn,
  output logic       ring
);

  localparam logic [6:0] SNOOZE_ADD = 7'(SNOOZE_MIN);
  localparam logic [3:0] RING_LIM   = 4'(RING_MIN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [6:0] base_min, base_min_n;
  logic [6:0] base_hr, base_hr_n;
  logic [6:0] amin_n, ahrs_n;
  logic       alarm_on_n, ring_n;
  logic       buzz_q;
  logic [3:0] ring_cnt, ring_cnt_n;

  logic       rise;
  logic       arm_drop;     // armToggle about to disarm the alarm
  logic [6:0] base_min_inc, base_hr_inc;
  logic [6:0] snz_min_sum, snz_min, snz_hr;
  logic [3:0] ring_cnt_inc;

  assign rise     = buzz & ~buzz_q;
  assign arm_drop = armToggle & alarmOn;

  assign base_min_inc = (base_min == 7'd59) ? 7'd0 : base_min + 7'd1;
  assign base_hr_inc  = (base_hr  == 7'd23) ? 7'd0 : base_hr  + 7'd1;
  assign ring_cnt_inc = ring_cnt + 4'd1;

  // Snooze adds to the active compare time (which may already be snoozed),
  // so repeated snoozes accumulate. Max sum is 59+59, which fits in 7 bits.
  always_comb begin
    snz_min_sum = amin + SNOOZE_ADD;
    snz_min     = snz_min_sum;
    snz_hr      = ahrs;
    if (snz_min_sum >= 7'd60) begin
      snz_min = snz_min_sum - 7'd60;
      snz_hr  = (ahrs == 7'd23) ? 7'd0 : ahrs + 7'd1;
    end
  end

  // Next-state and next-register logic. Restore is expressed by overwriting
  // the defaults with the base time and IDLE.
  always_comb begin
    state_n    = state;
    base_min_n = base_min;
    base_hr_n  = base_hr;
    amin_n     = amin;
    ahrs_n     = ahrs;
    ring_n     = ring;
    ring_cnt_n = ring_cnt;
    alarm_on_n = armToggle ? ~alarmOn : alarmOn;

    unique case (state)
      IDLE: begin
        if (setAlarm && advMin) begin
          base_min_n = base_min_inc;
          amin_n     = base_min_inc;
        end
        if (setAlarm && advHr) begin
          base_hr_n = base_hr_inc;
          ahrs_n    = base_hr_inc;
        end
        if (rise) begin
          ring_n     = 1'b1;
          ring_cnt_n = 4'd0;
          state_n    = RINGING;
        end
      end

      RINGING: begin
        if (stop || arm_drop) begin
          amin_n     = base_min;
          ahrs_n     = base_hr;
          ring_n     = 1'b0;
          ring_cnt_n = 4'd0;
          state_n    = IDLE;
        end else if (snooze) begin
          ring_n  = 1'b0;
          amin_n  = snz_min;
          ahrs_n  = snz_hr;
          state_n = SNOOZED;
        end else if (min_tick) begin
          if (ring_cnt_inc == RING_LIM) begin
            amin_n     = base_min;
            ahrs_n     = base_hr;
            ring_n     = 1'b0;
            ring_cnt_n = 4'd0;
            state_n    = IDLE;
          end else begin
            ring_cnt_n = ring_cnt_inc;
          end
        end
      end

      SNOOZED: begin
        if (stop || arm_drop) begin
          amin_n     = base_min;
          ahrs_n     = base_hr;
          ring_n     = 1'b0;
          ring_cnt_n = 4'd0;
          state_n    = IDLE;
        end else if (rise) begin
          ring_n     = 1'b1;
          ring_cnt_n = 4'd0;
          state_n    = RINGING;
        end
      end

      default: begin
        amin_n     = base_min;
        ahrs_n     = base_hr;
        ring_n     = 1'b0;
        ring_cnt_n = 4'd0;
        state_n    = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      base_min <= 7'd0;
      base_hr  <= 7'd0;
      amin     <= 7'd0;
      ahrs     <= 7'd0;
      alarmOn  <= 1'b0;
      ring     <= 1'b0;
      buzz_q   <= 1'b0;
      ring_cnt <= 4'd0;
    end else begin
      state    <= state_n;
      base_min <= base_min_n;
      base_hr  <= base_hr_n;
      amin     <= amin_n;
      ahrs     <= ahrs_n;
      alarmOn  <= alarm_on_n;
      ring     <= ring_n;
      buzz_q   <= buzz;
      ring_cnt <= ring_cnt_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
// ============================================================================
//  Module   : tb_alarm_ctrl
//  Purpose  : Self-checking bench for alarm_ctrl (default parameters,
//             SNOOZE_MIN = 9, RING_MIN = 2). Table of per-cycle vectors plus
//             hand-written sequences for set/wrap, day wrap and async reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       buzz = 1'b0, min_tick = 1'b0, setAlarm = 1'b0, advMin = 1'b0;
  logic       advHr = 1'b0, armToggle = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic [6:0] amin, ahrs;
  logic       alarmOn, ring;

  int errors = 0;
  int checks = 0;

  // Input bit positions for the vector table.
  localparam logic [7:0] B  = 8'h80;  // buzz
  localparam logic [7:0] T  = 8'h40;  // min_tick
  localparam logic [7:0] SA = 8'h20;  // setAlarm
  localparam logic [7:0] AM = 8'h10;  // advMin
  localparam logic [7:0] AH = 8'h08;  // advHr
  localparam logic [7:0] AT = 8'h04;  // armToggle
  localparam logic [7:0] SN = 8'h02;  // snooze
  localparam logic [7:0] ST = 8'h01;  // stop

  typedef struct {
    logic [7:0] in;
    logic [6:0] e_min;
    logic [6:0] e_hr;
    logic       e_on;
    logic       e_ring;
  } vec_t;

  vec_t tbl[$];

  alarm_ctrl #(.SNOOZE_MIN(9), .RING_MIN(2)) dut (
    .Clk(Clk), .Reset(Reset), .buzz(buzz), .min_tick(min_tick),
    .setAlarm(setAlarm), .advMin(advMin), .advHr(advHr),
    .armToggle(armToggle), .snooze(snooze), .stop(stop),
    .amin(amin), .ahrs(ahrs), .alarmOn(alarmOn), .ring(ring)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [6:0] m, input logic [6:0] h,
                       input logic on, input logic r);
    checks++;
    if (amin !== m || ahrs !== h || alarmOn !== on || ring !== r) begin
      errors++;
      $display("FAIL %s: got amin=%0d ahrs=%0d alarmOn=%0b ring=%0b, want amin=%0d ahrs=%0d alarmOn=%0b ring=%0b",
               name, amin, ahrs, alarmOn, ring, m, h, on, r);
    end
  endtask

  // Apply one cycle of inputs; pulses are dropped after the sampling edge.
  // buzz and setAlarm are levels taken from the vector too.
  task automatic step(input logic [7:0] in);
    buzz      = in[7];
    min_tick  = in[6];
    setAlarm  = in[5];
    advMin    = in[4];
    advHr     = in[3];
    armToggle = in[2];
    snooze    = in[1];
    stop      = in[0];
    @(posedge Clk);
    #1;
    min_tick = 1'b0; advMin = 1'b0; advHr = 1'b0;
    armToggle = 1'b0; snooze = 1'b0; stop = 1'b0;
  endtask

  task automatic add(input logic [7:0] in, input int m, input int h,
                     input logic on, input logic r);
    vec_t v;
    v.in = in; v.e_min = 7'(m); v.e_hr = 7'(h); v.e_on = on; v.e_ring = r;
    tbl.push_back(v);
  endtask

  initial begin
    // ---------------- Table: starts from 07:30 armed, IDLE, buzz_q = 0
    // ring / stop / no re-ring within the minute
    add(B,        30, 7, 1, 1);
    add(B,        30, 7, 1, 1);
    add(B | ST,   30, 7, 1, 0);
    add(B,        30, 7, 1, 0);
    add(B,        30, 7, 1, 0);
    add(8'h00,    30, 7, 1, 0);
    // snooze + stop together: restore, no add
    add(B,        30, 7, 1, 1);
    add(B|SN|ST,  30, 7, 1, 0);
    add(8'h00,    30, 7, 1, 0);
    // adjust ignored while ringing, then snooze, adjust ignored while snoozed
    add(B,        30, 7, 1, 1);
    add(B|SA|AM|AH, 30, 7, 1, 1);
    add(B | SN,   39, 7, 1, 0);
    add(8'h00,    39, 7, 1, 0);
    add(SA | AM,  39, 7, 1, 0);
    // armToggle while snoozed: disarm and restore to IDLE; IDLE editing works
    add(AT,       30, 7, 0, 0);
    add(SA | AM,  31, 7, 0, 0);
    add(AT,       31, 7, 1, 0);
    // timeout: tick on entry edge is not counted, second counted tick stops
    add(B | T,    31, 7, 1, 1);
    add(B | T,    31, 7, 1, 1);
    add(B,        31, 7, 1, 1);
    add(T,        31, 7, 1, 0);
    add(8'h00,    31, 7, 1, 0);
    // repeated snoozes accumulate; stop from SNOOZED restores base
    add(B,        31, 7, 1, 1);
    add(B | SN,   40, 7, 1, 0);
    add(8'h00,    40, 7, 1, 0);
    add(B,        40, 7, 1, 1);
    add(B | SN,   49, 7, 1, 0);
    add(8'h00,    49, 7, 1, 0);
    add(ST,       31, 7, 1, 0);
    // armToggle off beats snooze
    add(B,        31, 7, 1, 1);
    add(B|AT|SN,  31, 7, 0, 0);
    add(8'h00,    31, 7, 0, 0);
    add(AT,       31, 7, 1, 0);

    // ---------------- Reset state
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("reset", 7'd0, 7'd0, 1'b0, 1'b0);

    // Adjust without setAlarm is ignored; both pulses together both apply
    step(AM | AH);
    check("adj_no_set", 7'd0, 7'd0, 1'b0, 1'b0);
    step(SA | AM | AH);
    check("adj_both", 7'd1, 7'd1, 1'b0, 1'b0);

    // ---------------- Set alarm to 07:30 and arm (from 01:01)
    for (int i = 0; i < 6; i++) step(SA | AH);
    for (int i = 0; i < 29; i++) step(SA | AM);
    step(SA | AT);
    check("set_0730", 7'd30, 7'd7, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) step(SA | AM);
    check("min_wrap", 7'd30, 7'd7, 1'b1, 1'b0);
    step(8'h00);

    // ---------------- Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].in);
      check($sformatf("vec%0d", i), tbl[i].e_min, tbl[i].e_hr, tbl[i].e_on, tbl[i].e_ring);
    end

    // ---------------- Snooze across hour and day: 07:31 -> 23:55
    for (int i = 0; i < 16; i++) step(SA | AH);
    for (int i = 0; i < 24; i++) step(SA | AM);
    step(8'h00);
    check("set_2355", 7'd55, 7'd23, 1'b1, 1'b0);
    step(B);
    check("ring_2355", 7'd55, 7'd23, 1'b1, 1'b1);
    step(B | SN);
    check("snooze_wrap", 7'd4, 7'd0, 1'b1, 1'b0);
    step(8'h00);
    step(B);
    check("reRing_0004", 7'd4, 7'd0, 1'b1, 1'b1);
    step(B | ST);
    check("stop_restore", 7'd55, 7'd23, 1'b1, 1'b0);
    step(8'h00);

    // ---------------- Asynchronous reset mid-ring, before the next edge
    step(B);
    check("ring_before_rst", 7'd55, 7'd23, 1'b1, 1'b1);
    #2 Reset = 1'b1;
    #1;
    check("async_reset", 7'd0, 7'd0, 1'b0, 1'b0);
    buzz = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    step(8'h00);
    check("after_reset", 7'd0, 7'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
